// File: rtl/comparator_bist_if.sv
// Bus between the comparator self-test engine and its host / comparator under test.
// The master side issues start, supplies the comparator flags and reads the results.
// The slave side is the engine: it drives the operands and the status outputs.
interface comparator_bist_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             start;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             dut_g;
    logic             dut_e;
    logic             dut_l;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    modport master (
        output start, dut_g, dut_e, dut_l,
        input  cmp_a, cmp_b, busy, done, pass, err_count, fail_a, fail_b
    );

    modport slave (
        input  start, dut_g, dut_e, dut_l,
        output cmp_a, cmp_b, busy, done, pass, err_count, fail_a, fail_b
    );
endinterface

// File: rtl/comparator_bist.sv
// Self-test engine for a WIDTH-bit magnitude comparator.
// It sweeps every (a,b) pair with b as the inner index, holds each vector for SETTLE
// cycles, then checks the gt/eq/lt response against the unsigned golden result.
// It counts mismatches (saturating) and latches the first failing vector.
module comparator_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    comparator_bist_if.slave bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic [WIDTH-1:0] OP_ZERO     = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Golden one-hot {gt, eq, lt} for an unsigned compare.
    function automatic logic [2:0] golden_flags(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [2:0] f;
        if (a > b) begin
            f = 3'b100;
        end else if (a == b) begin
            f = 3'b010;
        end else begin
            f = 3'b001;
        end
        return f;
    endfunction

    state_t           state_r,  state_s;
    logic [WIDTH-1:0] cmp_a_r,  cmp_a_s;
    logic [WIDTH-1:0] cmp_b_r,  cmp_b_s;
    logic [SW-1:0]    settle_r, settle_s;
    logic             busy_r,   busy_s;
    logic             done_r,   done_s;
    logic [ERR_W-1:0] err_r,    err_s;
    logic [WIDTH-1:0] fail_a_r, fail_a_s;
    logic [WIDTH-1:0] fail_b_r, fail_b_s;
    logic             first_r,  first_s;

    logic [2*WIDTH-1:0] idx_next_s;
    logic               mismatch_s;
    logic               last_s;

    // Next-state and next-output logic of the sweep FSM.
    always_comb begin
        state_s    = state_r;
        cmp_a_s    = cmp_a_r;
        cmp_b_s    = cmp_b_r;
        settle_s   = settle_r;
        busy_s     = busy_r;
        done_s     = done_r;
        err_s      = err_r;
        fail_a_s   = fail_a_r;
        fail_b_s   = fail_b_r;
        first_s    = first_r;
        idx_next_s = {cmp_a_r, cmp_b_r} + (2*WIDTH)'(1);
        mismatch_s = ({bus.dut_g, bus.dut_e, bus.dut_l} != golden_flags(cmp_a_r, cmp_b_r));
        last_s     = (cmp_a_r == ALL_ONES) && (cmp_b_r == ALL_ONES);

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_s  = APPLY;
                    cmp_a_s  = OP_ZERO;
                    cmp_b_s  = OP_ZERO;
                    settle_s = {SW{1'b0}};
                    busy_s   = 1'b1;
                    done_s   = 1'b0;
                    err_s    = ERR_ZERO;
                    fail_a_s = OP_ZERO;
                    fail_b_s = OP_ZERO;
                    first_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            APPLY: begin
                if (settle_r == SETTLE_LAST) begin
                    state_s  = CHECK;
                    settle_s = {SW{1'b0}};
                end else begin
                    settle_s = settle_r + SW'(1);
                end
            end
            CHECK: begin
                if (mismatch_s) begin
                    if (err_r != ERR_MAX) begin
                        err_s = err_r + ERR_W'(1);
                    end else begin
                        err_s = err_r;
                    end
                    if (!first_r) begin
                        first_s  = 1'b1;
                        fail_a_s = cmp_a_r;
                        fail_b_s = cmp_b_r;
                    end else begin
                        first_s = first_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (last_s) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = APPLY;
                    {cmp_a_s, cmp_b_s} = idx_next_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cmp_a_r  <= OP_ZERO;
            cmp_b_r  <= OP_ZERO;
            settle_r <= {SW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= ERR_ZERO;
            fail_a_r <= OP_ZERO;
            fail_b_r <= OP_ZERO;
            first_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            cmp_a_r  <= cmp_a_s;
            cmp_b_r  <= cmp_b_s;
            settle_r <= settle_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
            fail_a_r <= fail_a_s;
            fail_b_r <= fail_b_s;
            first_r  <= first_s;
        end
    end

    assign bus.cmp_a     = cmp_a_r;
    assign bus.cmp_b     = cmp_b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err_count = err_r;
    assign bus.fail_a    = fail_a_r;
    assign bus.fail_b    = fail_b_r;
    assign bus.pass      = done_r && (err_r == ERR_ZERO);
endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: a faulty-or-correct comparator model answers the engine,
// a reference model predicts each sweep's outcome into a scoreboard queue, and a
// monitor pops and checks whenever done rises.
module tb_comparator_bist;
    localparam int WIDTH  = 4;
    localparam int SETTLE = 1;
    localparam int ERR_W  = 8;
    localparam int V      = 1 << (2 * WIDTH);
    localparam int ERR_SAT = (1 << ERR_W) - 1;

    typedef struct {
        int err;
        int fa;
        int fb;
        int pass;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    comparator_bist_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    comparator_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_fail   = 0;
    exp_t      sb[$];
    time       start_time = 0;
    int        fault_mode = 0;
    logic [2:0] flip [V];
    logic [2:0] resp_s;

    // Response of the comparator under test, possibly with a planted fault.
    function automatic logic [2:0] resp_fn(input int mode, input int a, input int b,
                                           input logic [2:0] fl);
        logic [2:0] g;
        g = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
        case (mode)
            0:       return g;
            1:       return g & 3'b101;
            2:       return {g[0], g[1], g[2]};
            3:       return 3'b111;
            4:       return g ^ fl;
            default: return g;
        endcase
    endfunction

    assign resp_s    = resp_fn(fault_mode, int'(bus.cmp_a), int'(bus.cmp_b),
                               flip[{bus.cmp_a, bus.cmp_b}]);
    assign bus.dut_g = resp_s[2];
    assign bus.dut_e = resp_s[1];
    assign bus.dut_l = resp_s[0];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference outcome of a full sweep from the plain compare rules.
    task automatic predict(input int mode);
        exp_t e;
        int   errs;
        bit   found;
        logic [2:0] g;
        errs  = 0;
        found = 1'b0;
        e.fa  = 0;
        e.fb  = 0;
        for (int a = 0; a < (1 << WIDTH); a++) begin
            for (int b = 0; b < (1 << WIDTH); b++) begin
                g = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
                if (resp_fn(mode, a, b, flip[a * (1 << WIDTH) + b]) != g) begin
                    errs++;
                    if (!found) begin
                        found = 1'b1;
                        e.fa  = a;
                        e.fb  = b;
                    end
                end
            end
        end
        e.err  = (errs > ERR_SAT) ? ERR_SAT : errs;
        e.pass = (errs == 0) ? 1 : 0;
        e.lat  = V * (SETTLE + 1);
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        start_time = $time;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_sweep(input int mode, input bit mid_pulse);
        fault_mode = mode;
        for (int i = 0; i < V; i++) begin
            flip[i] = 3'b000;
            if (mode == 4 && $urandom_range(0, 7) == 0) flip[i] = 3'($urandom_range(1, 7));
        end
        predict(mode);
        pulse_start();
        if (mid_pulse) begin
            repeat (100) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done(V * (SETTLE + 1) + 200);
    endtask

    // Monitor: checks the predicted outcome each time done rises.
    initial begin
        exp_t e;
        logic prev_done;
        int   lat;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !prev_done) begin
                lat = int'(($time - start_time - 5) / 10);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("err_count", int'(bus.err_count), e.err);
                    check("fail_a", int'(bus.fail_a), e.fa);
                    check("fail_b", int'(bus.fail_b), e.fb);
                    check("pass", int'(bus.pass), e.pass);
                    check("done_latency", lat, e.lat);
                    check("busy_at_done", int'(bus.busy), 0);
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_cmp_a"}, int'(bus.cmp_a), 0);
        check({tag, "_cmp_b"}, int'(bus.cmp_b), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_pass"}, int'(bus.pass), 0);
        check({tag, "_err"}, int'(bus.err_count), 0);
        check({tag, "_fail_a"}, int'(bus.fail_a), 0);
        check({tag, "_fail_b"}, int'(bus.fail_b), 0);
    endtask

    initial begin
        bit hit;
        bus.start = 1'b0;
        for (int i = 0; i < V; i++) flip[i] = 3'b000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        // Correct comparator, with an ignored start pulse mid-sweep.
        run_sweep(0, 1'b1);
        // e stuck at 0.
        run_sweep(1, 1'b0);

        // Restart from DONE clears the results and reruns the sweep.
        fault_mode = 0;
        predict(0);
        pulse_start();
        check("restart_done", int'(bus.done), 0);
        check("restart_busy", int'(bus.busy), 1);
        check("restart_err", int'(bus.err_count), 0);
        check("restart_fail_a", int'(bus.fail_a), 0);
        wait_done(V * (SETTLE + 1) + 200);

        // g and l swapped; all flags high (saturation).
        run_sweep(2, 1'b0);
        run_sweep(3, 1'b0);

        // Reset in the middle of a sweep at vector (3,7).
        fault_mode = 0;
        predict(0);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (bus.cmp_a == 4'd3 && bus.cmp_b == 4'd7) hit = 1'b1;
            else @(negedge clk);
        end
        check("reached_3_7", int'(hit), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        check("post_reset_idle", int'(bus.busy), 0);
        run_sweep(0, 1'b0);

        // Randomly corrupted responses.
        for (int r = 0; r < 3; r++) run_sweep(4, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
